// File: rtl/piso_serializer_pkg.sv
// ==== piso_serializer_pkg : shared FSM encodings and width helper (rev 1.0) ====
`default_nettype none

package piso_serializer_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_reg.sv
// ==== piso_shift_reg : loadable zero-fill shift register feeding the serial output (rev 1.0) ====
`default_nettype none

module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg[WIDTH-2:0], 1'b0};
      assign bit_out = shreg[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {1'b0, shreg[WIDTH-1:1]};
      assign bit_out = shreg[0];
    end
  endgenerate

  // Load wins over shift so a back-to-back word replaces the drained one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= shifted;
    end
  end

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ==== piso_serializer : valid/ready parallel-in, serial-out transmitter (rev 1.0) ====
`default_nettype none

module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("piso_serializer: WIDTH must be >= 2");
    end
  endgenerate

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_q;
  logic             load_fire;
  logic             shift_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (load_valid) state_next = ST_SHIFT;
      ST_SHIFT: if (ser_ready && last_q) state_next = load_valid ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // load_ready deliberately depends combinationally on ser_ready for gapless words.
  always_comb begin
    load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && last_q && ser_ready);
    load_fire  = load_valid && load_ready;
    shift_fire = (state == ST_SHIFT) && ser_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      last_q <= 1'b0;
    end else if (load_fire) begin
      cnt    <= CNT_W'(WIDTH - 1);
      last_q <= 1'b0;
    end else if (shift_fire) begin
      if (!last_q) cnt <= cnt - 1'b1;
      last_q <= (cnt == CNT_W'(1));
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_fire),
    .shift_en  (shift_fire),
    .load_data (load_data),
    .bit_out   (ser_out)
  );

  assign ser_valid = (state == ST_SHIFT);
  assign busy      = (state == ST_SHIFT);
  assign ser_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ==== tb_piso_serializer : MSB-first and LSB-first instances against a bit-queue reference (rev 1.0) ====
`default_nettype none

module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         ser_ready;

  logic m_load_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy;
  logic l_load_ready, l_ser_valid, l_ser_out, l_ser_last, l_busy;

  int total = 0;
  int bad   = 0;

  // Reference: bits still owed for the in-flight word, in emission order.
  int rem = 0;
  bit q_m[$];
  bit q_l[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_load_ready),
    .load_data(load_data), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
    .ser_out(m_ser_out), .ser_last(m_ser_last), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_load_ready),
    .load_data(load_data), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
    .ser_out(l_ser_out), .ser_last(l_ser_last), .busy(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_m_valid"}, 32'(m_ser_valid), 0);
    check({tag, "_m_busy"},  32'(m_busy), 0);
    check({tag, "_m_ready"}, 32'(m_load_ready), 1);
    check({tag, "_m_out"},   32'(m_ser_out), 0);
    check({tag, "_m_last"},  32'(m_ser_last), 0);
    check({tag, "_l_valid"}, 32'(l_ser_valid), 0);
    check({tag, "_l_busy"},  32'(l_busy), 0);
    check({tag, "_l_ready"}, 32'(l_load_ready), 1);
    check({tag, "_l_out"},   32'(l_ser_out), 0);
    check({tag, "_l_last"},  32'(l_ser_last), 0);
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance the model.
  task automatic cycle(input bit lv, input logic [W-1:0] ld, input bit sr);
    bit exp_ready;
    @(negedge clk);
    load_valid = lv;
    load_data  = ld;
    ser_ready  = sr;
    #1;
    exp_ready = (rem == 0) || (rem == 1 && sr);
    check("m_valid", 32'(m_ser_valid), 32'(rem > 0));
    check("l_valid", 32'(l_ser_valid), 32'(rem > 0));
    check("m_busy",  32'(m_busy), 32'(rem > 0));
    check("l_busy",  32'(l_busy), 32'(rem > 0));
    check("m_ready", 32'(m_load_ready), 32'(exp_ready));
    check("l_ready", 32'(l_load_ready), 32'(exp_ready));
    if (rem > 0) begin
      check("m_bit",  32'(m_ser_out), 32'(q_m[0]));
      check("l_bit",  32'(l_ser_out), 32'(q_l[0]));
      check("m_last", 32'(m_ser_last), 32'(rem == 1));
      check("l_last", 32'(l_ser_last), 32'(rem == 1));
    end
    if (rem > 0 && sr) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
      rem--;
    end
    if (lv && exp_ready) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(ld[W-1-i]);
        q_l.push_back(ld[i]);
      end
      rem = W;
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
    #3;
    check_idle_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single word A5 with the consumer always ready.
    cycle(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b1);

    // Single-bit word exercises LSB-first ordering.
    cycle(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b1);

    // C3 with a three-cycle stall after the second bit.
    cycle(1'b1, 8'hC3, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < W; i++) cycle(1'b0, 8'h00, 1'b1);

    // Back-to-back FF then 00 with load_valid held.
    cycle(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b1);

    // A load pulse while busy must be ignored.
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < W + 1; i++) cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-word: outputs must fall before the next clock edge.
    cycle(1'b1, 8'h96, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_reset("midrst");
    rem = 0;
    q_m.delete();
    q_l.delete();
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 2 * W && rem > 0; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drain", 32'(rem), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
